// File: rtl/ysyx_22040759_define.sv
// Shared constants for the instruction fetch unit: FSM encoding, the NOP word
// substituted on faults, and the default boot address.
package ysyx_22040759_define;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        OUT  = 3'd3,
        NEXT = 3'd4
    } ifu_state_e;

    localparam logic [31:0] INST_NOP         = 32'h0000_0013;
    localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;

endpackage

// File: rtl/ysyx_22040759_ifu_timer.sv
// Response timeout counter: counts enabled cycles after a clear and
// saturates at LIMIT, flagging expiry.
module ysyx_22040759_ifu_timer #(
    parameter logic [7:0] LIMIT = 8'd255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [7:0] count;

    assign expired = (count == LIMIT);

    always_ff @(posedge clk) begin
        if (rst || clear)
            count <= 8'd0;
        else if (enable && !expired)
            count <= count + 8'd1;
    end

endmodule

// File: rtl/ysyx_22040759_ifu.sv
// Instruction fetch unit: one outstanding fetch at a time, request/response to
// imem, then a registered instruction handed to decode with a valid/ready pair.
module ysyx_22040759_ifu
    import ysyx_22040759_define::*;
#(
    parameter logic [63:0] RESET_PC       = RESET_PC_DEFAULT,
    parameter logic [7:0]  TIMEOUT_CYCLES = 8'd255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] pc_new,
    input  logic        pc_new_valid,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_rdata,
    input  logic        imem_resp_err,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [63:0] inst_pc,
    output logic        fetch_err
);

    ifu_state_e  state, state_nxt;
    logic [63:0] pc;
    logic [31:0] inst_q;
    logic        err_q;
    logic        pc_aligned;
    logic        timeout;

    assign pc_aligned = (pc[1:0] == 2'b00);

    // Held clear outside WAIT so every WAIT visit starts counting from zero.
    ysyx_22040759_ifu_timer #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (state != WAIT),
        .enable ((state == WAIT) && !imem_resp_valid),
        .expired(timeout)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: state_nxt = REQ;
            REQ:  if (!pc_aligned)                  state_nxt = OUT;
                  else if (imem_req_ready)          state_nxt = WAIT;
            WAIT: if (imem_resp_valid || timeout)   state_nxt = OUT;
            OUT:  if (inst_ready)                   state_nxt = NEXT;
            NEXT: if (pc_new_valid)                 state_nxt = REQ;
            default:                                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            pc     <= RESET_PC;
            inst_q <= INST_NOP;
            err_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                REQ: if (!pc_aligned) begin
                    inst_q <= INST_NOP;
                    err_q  <= 1'b1;
                end
                // A response wins over a timeout landing in the same cycle.
                WAIT: if (imem_resp_valid) begin
                    inst_q <= imem_rdata;
                    err_q  <= imem_resp_err;
                end else if (timeout) begin
                    inst_q <= INST_NOP;
                    err_q  <= 1'b1;
                end
                NEXT: if (pc_new_valid) pc <= pc_new;
                default: ;
            endcase
        end
    end

    assign imem_req_valid = (state == REQ) && pc_aligned;
    assign imem_addr      = pc;
    assign inst_valid     = (state == OUT);
    assign inst           = inst_q;
    assign inst_pc        = pc;
    assign fetch_err      = err_q;

endmodule

// File: doc/ysyx_22040759_ifu.md
YSYX_22040759_IFU -- requirements
Module: ysyx_22040759_ifu

Interface
REQ-001 Parameter RESET_PC, 64'h0000_0000_8000_0000, first fetch address after reset.
REQ-002 Parameter TIMEOUT_CYCLES, 8'd255, maximum wait cycles for an imem response.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 pc_new  input  64  next PC from the execute/writeback stage.
REQ-006 pc_new_valid  input  1  pc_new is valid this cycle.
REQ-007 imem_req_valid  output  1  fetch request valid.
REQ-008 imem_req_ready  input  1  memory accepts the request.
REQ-009 imem_addr  output  64  fetch address, equal to the current PC.
REQ-010 imem_resp_valid  input  1  response data valid.
REQ-011 imem_rdata  input  32  fetched instruction word.
REQ-012 imem_resp_err  input  1  bus error on the response.
REQ-013 inst_valid  output  1  instruction offered to decode.
REQ-014 inst_ready  input  1  decode accepts the instruction.
REQ-015 inst  output  32  instruction to decode.
REQ-016 inst_pc  output  64  PC of inst.
REQ-017 fetch_err  output  1  misaligned PC, bus error or timeout; qualifies inst.

Function
REQ-018 The FSM SHALL have exactly five states: IDLE, REQ, WAIT, OUT and NEXT.
REQ-019 IDLE SHALL move to REQ on the next clock unconditionally.
REQ-020 In REQ, imem_req_valid SHALL be 1 and imem_addr SHALL equal pc, held stable until imem_req_ready=1, then the FSM SHALL move to WAIT.
REQ-021 In REQ with pc[1:0]!=0, the FSM SHALL issue no request (imem_req_valid=0), SHALL latch inst=32'h0000_0013 with fetch_err=1, and SHALL move to OUT.
REQ-022 In WAIT, on imem_resp_valid=1 the FSM SHALL latch imem_rdata into inst, set fetch_err=imem_resp_err, and move to OUT.
REQ-023 In WAIT, a counter SHALL increment each cycle without a response; at count==TIMEOUT_CYCLES it SHALL latch inst=32'h0000_0013 with fetch_err=1 and move to OUT.
REQ-024 The timeout counter SHALL clear on entry to WAIT.
REQ-025 Once the FSM has left WAIT, any late imem_resp_valid SHALL be ignored.
REQ-026 In OUT, inst_valid SHALL be 1, and inst, inst_pc and fetch_err SHALL be stable until inst_ready=1, then the FSM SHALL move to NEXT.
REQ-027 In NEXT, on pc_new_valid=1 the module SHALL load pc<=pc_new and move to REQ.
REQ-028 pc_new_valid in any state other than NEXT SHALL be ignored.
REQ-029 A request SHALL be issued no earlier than the cycle after the state enters REQ.
REQ-030 Best-case latency from reset release to inst_valid SHALL be 3 cycles (IDLE, REQ with ready=1, WAIT with resp_valid=1).
REQ-031 Simultaneous imem_resp_valid and timeout in the same cycle SHALL take the response.
REQ-032 inst_pc SHALL equal the pc used for the corresponding request.
REQ-033 PC arithmetic SHALL be 64-bit with no wrap checks.

Reset
REQ-034 While rst=1 at a clock edge: state<=IDLE, pc<=RESET_PC, inst<=32'h0000_0013, fetch_err<=0, counter<=0.
REQ-035 imem_req_valid and inst_valid SHALL be 0 in IDLE and therefore 0 the cycle after any reset edge.
REQ-036 Reset asserted in REQ, WAIT or OUT SHALL abandon the transaction without further handshakes.

Structure
REQ-037 State encodings, the NOP constant 32'h0000_0013 and the RESET_PC default SHALL reside in ysyx_22040759_define.
REQ-038 The timeout counter SHALL be a sub-module named ysyx_22040759_ifu_timer with clear, enable and expired ports.
REQ-039 Outputs SHALL be driven from registers or from decoded state only, with no combinational input-to-output path except imem_addr=pc.

Verification
REQ-040 Reset release; ready=1; response after 1 cycle with rdata=32'h00100073 -> inst_valid on cycle 3, inst=32'h00100073, inst_pc=64'h80000000, fetch_err=0.
REQ-041 imem_req_ready held 0 for 5 cycles -> imem_req_valid=1 and imem_addr stable for all 5 cycles, then exactly one request accepted.
REQ-042 pc_new=64'h80000002 in NEXT -> no request, inst=32'h00000013, fetch_err=1, inst_pc=64'h80000002.
REQ-043 No response for 255 cycles in WAIT -> fetch_err=1 and NOP in OUT; a response arriving afterwards is ignored.
REQ-044 inst_ready held 0 for 4 cycles with pc_new_valid pulsed in OUT -> inst stable throughout, pulse ignored, FSM waits in NEXT.
REQ-045 rst pulsed in WAIT -> next cycle state=IDLE, both valid outputs 0, next request address=64'h80000000.
